universal_shift_reg: RTL
========================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL have the parameter INIT, default 0, giving the value of Q after reset.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, on these ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
REQ-004 The block SHALL have these further ports:
- enable  input  1  when 0, Q holds regardless of mode.
- mode  input  3  operation select.
- data_in  input  WIDTH  parallel load data.
- serial_in_r  input  1  bit entering at LSB on shift left.
- serial_in_l  input  1  bit entering at MSB on shift right.
- Q  output  WIDTH  register contents.
- Q_not  output  WIDTH  bitwise ~Q.
- msb_out  output  1  Q[WIDTH-1].
- lsb_out  output  1  Q[0].
- zero  output  1  high when Q == 0.
- op_count  output  8  count of non-hold operations since reset, saturating.

Function
REQ-005 All state changes SHALL occur on the rising edge of clock; Q SHALL reflect the operation one cycle after it is presented (latency 1).
REQ-006 With enable=1, mode SHALL select the operation as follows:
- 000 hold.
- 001 parallel load Q<=data_in.
- 010 shift left, Q<={Q[WIDTH-2:0],serial_in_r}.
- 011 shift right, Q<={serial_in_l,Q[WIDTH-1:1]}.
- 100 rotate left.
- 101 rotate right.
- 110 arithmetic shift right, MSB replicated.
- 111 synchronous clear to 0 (not INIT).
REQ-007 With enable=0, Q and op_count SHALL hold for every mode, including 111.
REQ-008 Q_not, msb_out, lsb_out and zero SHALL be combinational functions of the registered Q only, with no path from any input.
REQ-009 op_count SHALL increment by 1 on each enabled edge with mode != 000, SHALL saturate at 255, and SHALL NOT wrap.
REQ-010 At WIDTH=2, rotate and shift SHALL behave per REQ-006 with no special-casing.
REQ-011 A mode value changing between edges SHALL have no effect; only the value sampled at the edge matters.

Reset
REQ-012 While reset=0, Q SHALL be forced to INIT and op_count to 0 immediately, independent of clock.
REQ-013 During reset, Q_not SHALL equal ~INIT, and zero SHALL equal (INIT==0).
REQ-014 On reset release, the first edge with reset=1 SHALL perform the operation selected by the sampled mode/enable.
REQ-015 Reset asserted mid-sequence (e.g. during consecutive shifts) SHALL discard all in-progress state with no residual effect.
REQ-016 No initial blocks SHALL be used for state initialisation; reset is the only initialisation mechanism.

Structure
REQ-017 The eight mode encodings SHALL be defined as named constants in a shared include file (usr_defs.vh), used by both the RTL and the bench.
REQ-018 A per-bit sub-module usr_bit_cell SHALL hold one flop plus its 8:1 next-state mux (inputs: own bit, left neighbour, right neighbour, load bit, clear, sign bit) and SHALL be instantiated WIDTH times via generate.
REQ-019 The op_count saturation logic and the status outputs SHALL reside in the top level.

Verification
REQ-020 Reset and load, WIDTH=8, INIT=8'hA5: hold reset low -> Q=A5, Q_not=5A, op_count=0; release, mode=001 with data_in=3C -> Q=3C one edge later.
REQ-021 Shift-left chain: Q=81, mode=010, serial_in_r=1 for 2 edges -> Q=07, then 0F on a third edge; msb_out=0.
REQ-022 Rotate and arithmetic shift: Q=81, rotate right -> C0; Q=80, mode=110 three times -> F0; Q=40, mode=110 -> 20.
REQ-023 Enable gating and clear: Q=FF, enable=0 with mode=111 -> Q=FF, op_count unchanged; enable=1 -> Q=00, zero=1.
REQ-024 Saturation: 300 enabled shift operations -> op_count=255 and stays 255; mode=000 -> no change.
REQ-025 Asynchronous reset mid-operation: drop reset between edges during a shift sequence -> Q=INIT with no clock edge; the next edge after release applies the sampled mode; repeat at WIDTH=2 with rotate left on Q=01 -> Q=10.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// rtl/universal_shift_reg_pkg.sv - shared mode encodings and constants for the universal shift register
//
// Purpose : one place for the operation encodings used by the RTL and the bench.
// Contents: mode_t     - 3-bit operation select
//           OP_CNT_MAX - saturation value of the operation counter
package universal_shift_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } mode_t;

   localparam logic [7:0] OP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one bit of the universal shift register: flop plus next-state mux
//
// Purpose : holds a single register bit and selects its next value from the
//           operation mode.
// Ports   : clock, reset (async, active-low)
//           enable - 0 holds the bit
//           mode   - operation select
//           left   - next bit toward the MSB (or the MSB-side entry bit)
//           right  - next bit toward the LSB (or the LSB-side entry bit)
//           load   - parallel load bit
//           clear  - synchronous clear request (already decoded from mode)
//           sign   - register MSB, used by the arithmetic shift in the top cell
//           q      - registered bit
module usr_bit_cell
   import universal_shift_reg_pkg::*;
#(
   parameter logic INIT_BIT = 1'b0,
   parameter bit   IS_MSB   = 1'b0
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  enable,
   input  mode_t mode,
   input  logic  left,
   input  logic  right,
   input  logic  load,
   input  logic  clear,
   input  logic  sign,
   output logic  q
);

   logic nxt;

   // Shift and rotate share the same neighbour port; the top level decides
   // what feeds the end cells (serial input versus wrap-around bit).
   always_comb begin
      nxt = q;
      if (clear) begin
         nxt = 1'b0;
      end else begin
         case (mode)
            MODE_HOLD: nxt = q;
            MODE_LOAD: nxt = load;
            MODE_SHL:  nxt = right;
            MODE_ROL:  nxt = right;
            MODE_SHR:  nxt = left;
            MODE_ROR:  nxt = left;
            MODE_ASR:  nxt = IS_MSB ? sign : left;
            default:   nxt = q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= INIT_BIT;
      end else if (enable) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with status outputs and operation counter
//
// Purpose : WIDTH-bit register supporting hold, load, logical shifts, rotates,
//           arithmetic shift right and clear, built from per-bit cells.
// Ports   : clock, reset (async, active-low)
//           enable      - 0 holds Q and op_count
//           mode        - operation select (see mode_t)
//           data_in     - parallel load data
//           serial_in_r - bit entering at LSB on shift left
//           serial_in_l - bit entering at MSB on shift right
//           Q, Q_not    - register contents and its complement
//           msb_out, lsb_out, zero - status taken from registered Q only
//           op_count    - saturating count of enabled non-hold operations
module universal_shift_reg
   import universal_shift_reg_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in_r,
   input  logic             serial_in_l,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_not,
   output logic             msb_out,
   output logic             lsb_out,
   output logic             zero,
   output logic [7:0]       op_count
);

   mode_t mode_s;
   logic  clear;

   assign mode_s = mode_t'(mode);
   assign clear  = (mode_s == MODE_CLR);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic left_nb;
      logic right_nb;

      // LSB cell: serial input on shift left, wrap from MSB on rotate left.
      if (i == 0) begin : g_lsb
         assign right_nb = (mode_s == MODE_ROL) ? Q[WIDTH-1] : serial_in_r;
      end else begin : g_rin
         assign right_nb = Q[i-1];
      end

      // MSB cell: serial input on shift right, wrap from LSB on rotate right.
      if (i == WIDTH - 1) begin : g_msb
         assign left_nb = (mode_s == MODE_ROR) ? Q[0] : serial_in_l;
      end else begin : g_lin
         assign left_nb = Q[i+1];
      end

      usr_bit_cell #(
         .INIT_BIT (INIT[i]),
         .IS_MSB   (i == WIDTH - 1)
      ) u_cell (
         .clock  (clock),
         .reset  (reset),
         .enable (enable),
         .mode   (mode_s),
         .left   (left_nb),
         .right  (right_nb),
         .load   (data_in[i]),
         .clear  (clear),
         .sign   (Q[WIDTH-1]),
         .q      (Q[i])
      );
   end

   assign Q_not   = ~Q;
   assign msb_out = Q[WIDTH-1];
   assign lsb_out = Q[0];
   assign zero    = (Q == '0);

   // Counter stops at its maximum rather than wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_count <= 8'd0;
      end else if (enable && (mode_s != MODE_HOLD) && (op_count != OP_CNT_MAX)) begin
         op_count <= op_count + 8'd1;
      end
   end

endmodule
